// File: rtl/mem_port_arb.sv
// mem_port_arb: arbitrates one DRAM command port between two video line writers
// and one display read engine.
//
// Each grant runs BUSY -> GAP -> IDLE. A grant ends on the granted requester's
// done pulse, on a BUSY timeout, or when calibration is lost. Reads are capped
// at RD_MAX back-to-back grants while any write is pending. Writers alternate
// round-robin.
//
// Ports
//   cmd_clk      in   sole clock, rising edge
//   mem_rst_n    in   synchronous active-low reset
//   calib_done   in   DRAM calibration complete; low forces IDLE
//   wr_req[1:0]  in   per-writer line-ready request
//   wr_done[1:0] in   per-writer completion pulse
//   rd_req       in   read engine burst request
//   rd_done      in   read engine completion pulse
//   wr_probe     out  per-writer start enable, one-hot or zero
//   rd_probe     out  read engine start enable
//   arb_state    out  00 idle/gap, 01 read granted, 10 write granted
//   timeout_err  out  sticky BUSY-timeout flag
//   debug        out  {timeout_err, last_wr, rd_run[1:0], state[1:0], arb_state[1:0]}
//
// state | meaning
// IDLE  | waiting for calib_done and a request; decides the winner
// BUSY  | grant active; probe and arb_state held until done/timeout
// GAP   | forced idle for GAP_CYC cycles before the next decision

module mem_port_arb #(
    parameter int TIMEOUT = 4096,
    parameter int GAP_CYC = 2,
    parameter int RD_MAX  = 4
) (
    input  logic       cmd_clk,
    input  logic       mem_rst_n,
    input  logic       calib_done,
    input  logic [1:0] wr_req,
    input  logic [1:0] wr_done,
    input  logic       rd_req,
    input  logic       rd_done,
    output logic [1:0] wr_probe,
    output logic       rd_probe,
    output logic [1:0] arb_state,
    output logic       timeout_err,
    output logic [7:0] debug
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        GAP  = 2'b10
    } state_t;

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
    localparam logic [3:0]  RD_CAP   = 4'(RD_MAX);

    state_t      state;
    logic [15:0] timer;
    logic [3:0]  rd_run;
    logic        last_wr;

    logic        pick_rd;
    logic        wr_sel;
    logic        granted_done;

    // Winner selection for the IDLE decision.
    always_comb begin
        pick_rd = rd_req && ((rd_run < RD_CAP) || (wr_req == 2'b00));
        wr_sel  = 1'b0;
        case (wr_req)
            2'b01:   wr_sel = 1'b0;
            2'b10:   wr_sel = 1'b1;
            2'b11:   wr_sel = ~last_wr;
            default: wr_sel = 1'b0;
        endcase
    end

    // Probes are held constant through BUSY, so they identify whose done counts;
    // a done from anyone else is masked out here.
    assign granted_done = (rd_probe && rd_done) || (|(wr_probe & wr_done));

    always_ff @(posedge cmd_clk) begin
        if (!mem_rst_n) begin
            state       <= IDLE;
            wr_probe    <= 2'b00;
            rd_probe    <= 1'b0;
            arb_state   <= 2'b00;
            timer       <= '0;
            rd_run      <= '0;
            last_wr     <= 1'b1;
            timeout_err <= 1'b0;
        end else if (!calib_done) begin
            // rd_run and last_wr deliberately survive calibration loss.
            state     <= IDLE;
            wr_probe  <= 2'b00;
            rd_probe  <= 1'b0;
            arb_state <= 2'b00;
            timer     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (pick_rd) begin
                        state     <= BUSY;
                        rd_probe  <= 1'b1;
                        arb_state <= 2'b01;
                        if (rd_run != 4'hF)
                            rd_run <= rd_run + 4'd1;
                    end else if (wr_req != 2'b00) begin
                        state     <= BUSY;
                        wr_probe  <= wr_sel ? 2'b10 : 2'b01;
                        arb_state <= 2'b10;
                        last_wr   <= wr_sel;
                        rd_run    <= '0;
                    end
                end
                BUSY: begin
                    // done takes priority over a same-cycle timeout
                    if (granted_done || (timer == TO_LAST)) begin
                        if (!granted_done)
                            timeout_err <= 1'b1;
                        state     <= GAP;
                        wr_probe  <= 2'b00;
                        rd_probe  <= 1'b0;
                        arb_state <= 2'b00;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                GAP: begin
                    if (timer == GAP_LAST) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    wr_probe  <= 2'b00;
                    rd_probe  <= 1'b0;
                    arb_state <= 2'b00;
                    timer     <= '0;
                end
            endcase
        end
    end

    assign debug = {timeout_err, last_wr, rd_run[1:0], state, arb_state};

endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;

    localparam int TO  = 16;
    localparam int GAP = 2;

    // grant vector layout: {rd_probe, wr_probe[1:0], arb_state[1:0]}
    localparam logic [4:0] G_RD = 5'b1_00_01;
    localparam logic [4:0] G_W0 = 5'b0_01_10;
    localparam logic [4:0] G_W1 = 5'b0_10_10;

    logic       cmd_clk    = 1'b0;
    logic       mem_rst_n  = 1'b0;
    logic       calib_done = 1'b0;
    logic [1:0] wr_req     = 2'b00;
    logic [1:0] wr_done    = 2'b00;
    logic       rd_req     = 1'b0;
    logic       rd_done    = 1'b0;
    logic [1:0] wr_probe;
    logic       rd_probe;
    logic [1:0] arb_state;
    logic       timeout_err;
    logic [7:0] debug;

    int         checks = 0;
    int         errors = 0;
    logic [4:0] exp_q[$];
    logic [4:0] g;

    mem_port_arb #(.TIMEOUT(TO), .GAP_CYC(GAP), .RD_MAX(4)) dut (
        .cmd_clk    (cmd_clk),
        .mem_rst_n  (mem_rst_n),
        .calib_done (calib_done),
        .wr_req     (wr_req),
        .wr_done    (wr_done),
        .rd_req     (rd_req),
        .rd_done    (rd_done),
        .wr_probe   (wr_probe),
        .rd_probe   (rd_probe),
        .arb_state  (arb_state),
        .timeout_err(timeout_err),
        .debug      (debug)
    );

    always #5 cmd_clk = ~cmd_clk;

    function automatic logic [31:0] grant_vec();
        return 32'({rd_probe, wr_probe, arb_state});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge cmd_clk);
    endtask

    // Waits (bounded) for a grant, then compares it against the scoreboard head.
    task automatic wait_grant(input string tag, output int lat);
        lat = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge cmd_clk);
            if (arb_state != 2'b00) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=no_grant expected=grant", tag);
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_empty observed=%0h expected=no_grant", tag, grant_vec());
        end else begin
            check(tag, grant_vec(), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic finish_grant(input logic [4:0] gv);
        if (gv[4]) rd_done = 1'b1;
        else       wr_done = gv[3:2];
        cyc(1);
        rd_done = 1'b0;
        wr_done = 2'b00;
    endtask

    task automatic do_reset();
        mem_rst_n = 1'b0;
        cyc(2);
        mem_rst_n = 1'b1;
    endtask

    initial begin
        int lat;

        // reset state
        cyc(3);
        check("rst_wr_probe", 32'(wr_probe), 0);
        check("rst_rd_probe", 32'(rd_probe), 0);
        check("rst_arb_state", 32'(arb_state), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_debug", 32'(debug), 'h40);
        mem_rst_n  = 1'b1;
        calib_done = 1'b1;
        cyc(2);
        check("idle_no_req", grant_vec(), 0);

        // single write: latency, request drop during BUSY, GAP length
        wr_req = 2'b01;
        exp_q.push_back(G_W0);
        wait_grant("w0_first", lat);
        check("w0_latency", 32'(lat), 1);
        wr_req = 2'b00;
        cyc(3);
        check("hold_after_req_drop", grant_vec(), 32'(G_W0));
        finish_grant(G_W0);
        check("gap1_arb", 32'(arb_state), 0);
        check("gap1_state", 32'(debug[3:2]), 2);
        cyc(1);
        check("gap2_state", 32'(debug[3:2]), 2);
        check("gap2_probes", grant_vec(), 0);
        cyc(1);
        check("idle_after_gap", 32'(debug[3:2]), 0);

        // round-robin writers from reset, with minimum spacing
        do_reset();
        wr_req = 2'b11;
        exp_q.push_back(G_W0);
        exp_q.push_back(G_W1);
        exp_q.push_back(G_W0);
        exp_q.push_back(G_W1);
        for (int k = 0; k < 4; k++) begin
            g = exp_q[0];
            wait_grant($sformatf("rr%0d", k), lat);
            if (k > 0) check($sformatf("rr_spacing%0d", k), 32'(lat), GAP + 1);
            finish_grant(g);
        end
        wr_req = 2'b00;

        // read cap: 4 reads, then the pending write, then reads resume
        rd_req = 1'b1;
        wr_req = 2'b01;
        repeat (4) exp_q.push_back(G_RD);
        exp_q.push_back(G_W0);
        exp_q.push_back(G_RD);
        exp_q.push_back(G_RD);
        for (int k = 0; k < 7; k++) begin
            g = exp_q[0];
            wait_grant($sformatf("mix%0d", k), lat);
            finish_grant(g);
        end
        rd_req = 1'b0;
        wr_req = 2'b00;
        check("rd_run_after_mix", 32'(debug[5:4]), 2);

        // read grant: foreign done ignored, done+timeout same cycle is no error
        cyc(4);
        rd_req = 1'b1;
        exp_q.push_back(G_RD);
        wait_grant("rd_race", lat);
        rd_req  = 1'b0;
        wr_done = 2'b10;
        cyc(1);
        wr_done = 2'b00;
        check("ignore_wr_done1", grant_vec(), 32'(G_RD));
        cyc(TO - 2);
        check("rd_before_to", 32'(arb_state), 1);
        rd_done = 1'b1;
        cyc(1);
        rd_done = 1'b0;
        check("race_gap", 32'(arb_state), 0);
        check("race_no_err", 32'(timeout_err), 0);

        // write timeout sets the sticky error
        cyc(4);
        wr_req = 2'b01;
        exp_q.push_back(G_W0);
        wait_grant("to_grant", lat);
        wr_req = 2'b00;
        cyc(TO - 1);
        check("w_before_to", 32'(arb_state), 2);
        check("err_before_to", 32'(timeout_err), 0);
        cyc(1);
        check("to_gap", grant_vec(), 0);
        check("to_err_set", 32'(timeout_err), 1);
        rd_req = 1'b1;
        exp_q.push_back(G_RD);
        wait_grant("after_to_rd", lat);
        rd_req = 1'b0;
        finish_grant(G_RD);
        check("err_sticky", 32'(timeout_err), 1);

        // reset mid-BUSY with a done pending
        wr_req = 2'b01;
        exp_q.push_back(G_W0);
        wait_grant("pre_rst", lat);
        wr_req    = 2'b00;
        mem_rst_n = 1'b0;
        wr_done   = 2'b01;
        cyc(1);
        check("rst_drop", grant_vec(), 0);
        check("rst_err_clr", 32'(timeout_err), 0);
        cyc(1);
        wr_done   = 2'b00;
        mem_rst_n = 1'b1;
        cyc(1);
        check("rst_idle_debug", 32'(debug), 'h40);

        // calibration loss mid-BUSY, last_wr preserved
        wr_req = 2'b01;
        exp_q.push_back(G_W0);
        wait_grant("cal_w0", lat);
        finish_grant(G_W0);
        wr_req = 2'b11;
        exp_q.push_back(G_W1);
        wait_grant("cal_w1", lat);
        calib_done = 1'b0;
        cyc(1);
        check("cal_drop", grant_vec(), 0);
        cyc(2);
        check("cal_hold_idle", 32'(debug), 'h40);
        calib_done = 1'b1;
        exp_q.push_back(G_W0);
        wait_grant("cal_resume", lat);
        check("cal_resume_lat", 32'(lat), 1);
        wr_req = 2'b00;
        finish_grant(G_W0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096: cycles allowed in BUSY before abort (range 2..65535).
REQ-002 SHALL have parameter GAP_CYC, default 2: idle cycles forced between grants (range 1..15).
REQ-003 SHALL have parameter RD_MAX, default 4: max consecutive read grants while any write is pending (range 1..15).
REQ-004 SHALL have port cmd_clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port mem_rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port calib_done  in  1  DRAM calibration complete.
REQ-007 SHALL have port wr_req  in  2  per-writer request (bit i = video input i has a line ready).
REQ-008 SHALL have port wr_done  in  2  per-writer completion pulse (write command issued).
REQ-009 SHALL have port rd_req  in  1  display read engine requests a burst.
REQ-010 SHALL have port rd_done  in  1  read engine completion pulse.
REQ-011 SHALL have port wr_probe  out  2  per-writer start enable, one-hot or zero.
REQ-012 SHALL have port rd_probe  out  1  read engine start enable.
REQ-013 SHALL have port arb_state  out  2  00 idle/gap, 01 read granted, 10 write granted; 11 never driven.
REQ-014 SHALL have port timeout_err  out  1  sticky, set on any BUSY timeout.
REQ-015 SHALL have port debug  out  8  {timeout_err, last_wr, rd_run[1:0], state[1:0], arb_state[1:0]}.

Function
REQ-016 SHALL implement states IDLE, BUSY, GAP; all outputs registered.
REQ-017 In IDLE with calib_done=1, SHALL evaluate requests each cycle and go to BUSY on the next edge when any request is present.
REQ-018 Selection: read wins when rd_req=1 and (rd_run < RD_MAX or wr_req==0); otherwise a writer wins.
REQ-019 Writer choice SHALL be round-robin: when both wr_req bits are set, grant the index != last_wr; with one bit set, grant that one; then last_wr <= granted index.
REQ-020 rd_run (4-bit saturating) SHALL increment on each read grant and clear on each write grant.
REQ-021 Entering BUSY: granted probe=1, arb_state=01 (read) or 10 (write), visible the cycle after the deciding edge; the probe and arb_state SHALL hold constant for all of BUSY.
REQ-022 BUSY: timer counts from 0 each cycle; the granted requester's done=1 -> GAP.
REQ-023 BUSY: timer reaching TIMEOUT-1 without done -> GAP, and timeout_err <= 1.
REQ-024 Done and timeout in the same cycle SHALL count as done, with no error.
REQ-025 Done from a non-granted requester SHALL be ignored in every state.
REQ-026 A request deasserting during BUSY SHALL NOT end the grant; only done, timeout or calib loss end it.
REQ-027 GAP: all probes=0, arb_state=00, held exactly GAP_CYC cycles, then IDLE.
REQ-028 calib_done=0 in any state SHALL force IDLE on the next edge, with probes=0, arb_state=00 and the timer cleared; rd_run and last_wr are retained.
REQ-029 At most one probe SHALL be high in any cycle; a probe SHALL never be high while arb_state=00.
REQ-030 Minimum grant-to-grant spacing SHALL be 1 (BUSY) + GAP_CYC + 1 (IDLE decision) cycles.

Reset
REQ-031 With mem_rst_n=0 at an edge: state=IDLE, wr_probe=00, rd_probe=0, arb_state=00, timer=0, rd_run=0, last_wr=1 (writer 0 first), timeout_err=0.
REQ-032 Reset mid-BUSY SHALL drop all grants on that edge; a done arriving while in reset SHALL be ignored.

Verification
REQ-033 calib_done=1, wr_req=01 -> wr_probe=01 and arb_state=10 the cycle after the request is sampled; wr_done[0] pulse -> arb_state=00 for 2 cycles, then IDLE.
REQ-034 wr_req=11 held, each write completed by a done pulse -> grants alternate 0,1,0,1 with writer 0 first after reset.
REQ-035 rd_req=1 and wr_req=01 held -> 4 read grants, then 1 write grant, then reads resume.
REQ-036 Grant writer 0 with no done, TIMEOUT=16 -> GAP after 16 BUSY cycles and timeout_err=1; it stays 1 through later normal grants until mem_rst_n=0.
REQ-037 Read granted with rd_done and the timeout in the same cycle -> timeout_err stays 0; wr_done[1] pulse during a read grant -> no effect.
REQ-038 calib_done dropped mid-BUSY -> probes=0 and arb_state=00 next cycle; when calib_done returns, arbitration resumes with last_wr preserved.
